stream_demux_1_4: RTL and testbench
===================================

// Module: stream_demux_1_4
//
// PURPOSE
// - Registered 1-to-4 stream demultiplexer. One WIDTH-bit input stream is routed by in_sel to one of
//   four output streams, each backed by a one-entry buffer slot.
// - Data-path counterpart of mux_4_1. Sits between a single producer and four consumers.
// - Each output stalls independently. A stalled output blocks only beats addressed to it.
//
// PARAMETERS
// - WIDTH      4   data width of each beat, in bits
// - CNT_W      8   width of each per-output beat counter (used only when STREAM_DEMUX_CNT_EN is defined)
//
// PORTS
// - clk        in   1          clock; all state updates on the rising edge
// - rst        in   1          synchronous reset, active-high
// - in_valid   in   1          producer has a beat on in_data
// - in_ready   out  1          demux accepts the beat this cycle
// - in_data    in   WIDTH      input beat
// - in_sel     in   2          destination output index, 0..3; qualified by in_valid
// - out_valid  out  4          out_valid[i]: slot i holds a beat
// - out_ready  in   4          out_ready[i]: consumer i takes the beat this cycle
// - out_data   out  4*WIDTH    slot i data on out_data[i*WIDTH +: WIDTH]
// - out_cnt    out  4*CNT_W    present only with STREAM_DEMUX_CNT_EN; counter i on out_cnt[i*CNT_W +: CNT_W]
//
// BEHAVIOUR
// - Clocking and reset: one clock; reset is synchronous and active-high.
// - Per-slot state: EMPTY or FULL. out_valid[i] is 1 exactly when slot i is FULL.
// - Reset values: every slot EMPTY, out_valid = 4'b0000, out_data = 0, out_cnt = 0.
// - in_ready during reset: forced to 0 in every cycle where rst = 1.
// - in_ready when not in reset: !out_valid[in_sel] || out_ready[in_sel].
//   - Combinational from in_sel, out_valid and out_ready.
//   - Never depends on in_valid.
// - Push: occurs when in_valid && in_ready. On the next edge, slot in_sel loads in_data and becomes FULL.
// - Pop: occurs when out_valid[i] && out_ready[i]. On the next edge, slot i goes EMPTY, unless it is pushed in the same cycle.
// - Push and pop on the same slot in the same cycle: the slot reloads with the new beat and stays FULL.
//   This gives one beat per cycle per output with no bubble.
// - Push and pop on different slots in the same cycle: both take effect. The slots are independent.
// - Latency: a beat accepted in cycle N is on out_data[sel] with out_valid set in cycle N+1.
// - Stability: while out_valid[i] && !out_ready[i], out_data[i] holds its value.
// - Data order: beats to the same output leave in arrival order.
// - Slot FULL and not popped: in_ready is 0 for that in_sel. The producer must hold in_valid, in_data and in_sel until in_ready is 1.
// - Changing in_sel while in_valid = 1 and in_ready = 0 is a protocol violation. The block does not check for it.
// - out_data[i] while slot i is EMPTY keeps the last loaded value. Consumers must not use it.
// - Reset asserted mid-stream: every slot is flushed to EMPTY on that edge. Buffered beats are discarded. No pops are reported.
//
// CONFIGURATION
// - Macro: STREAM_DEMUX_CNT_EN
// - Defined:
//   - out_cnt port exists.
//   - Counter i increments by 1 on each edge that pushes into slot i.
//   - Counters wrap 2^CNT_W-1 -> 0 without saturation.
//   - Reset clears all counters.
// - Undefined: no out_cnt port and no counter flops. All other behaviour is identical.
//
// TESTING
// - Reset, then in_valid=0 -> out_valid=0000, in_ready=1, out_cnt=0.
//   Assert rst with in_valid=1 -> in_ready=0 and no push.
// - in_sel=2, in_data=4'hA pushed in cycle N, out_ready=1111 -> cycle N+1: out_valid=0100, out_data[11:8]=4'hA.
//   Cycle N+2: out_valid=0000.
// - out_ready[1]=0; push 4'h3 to sel 1, then present 4'h5 to sel 1 -> in_ready=0 and 4'h3 held.
//   Push 4'h7 to sel 0 -> accepted.
//   Raise out_ready[1] -> 4'h5 loads next edge, order 3 then 5.
// - Back-to-back beats to sel 3 with out_ready[3]=1 -> one beat per cycle, no bubble, in_ready stays 1.
// - Fill slots 0 and 2, then assert rst for one cycle -> out_valid=0000 after the edge.
//   The discarded beats never appear.
// - STREAM_DEMUX_CNT_EN, CNT_W=8: 257 pushes to sel 0 -> out_cnt[7:0]=1, other counters 0.

Source files
------------

// File: rtl/stream_demux_1_4_if.sv
// Handshake bundle for stream_demux_1_4: one producer-side stream in, four consumer-side streams out.
// Per-output beat counters (out_cnt) exist only when STREAM_DEMUX_CNT_EN is defined.
interface stream_demux_1_4_if #(
  parameter int WIDTH = 4
`ifdef STREAM_DEMUX_CNT_EN
  , parameter int CNT_W = 8
`endif
);
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   in_data;
  logic [1:0]         in_sel;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*WIDTH-1:0] out_data;
`ifdef STREAM_DEMUX_CNT_EN
  logic [4*CNT_W-1:0] out_cnt;

  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data, out_cnt
  );
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data, out_cnt
  );
`else
  modport master (
    output in_valid, in_data, in_sel, out_ready,
    input  in_ready, out_valid, out_data
  );
  modport slave (
    input  in_valid, in_data, in_sel, out_ready,
    output in_ready, out_valid, out_data
  );
`endif
endinterface

// File: rtl/stream_demux_1_4.sv
// Registered 1-to-4 stream demultiplexer with a one-entry slot per output.
// Optional per-output push counters are enabled by defining STREAM_DEMUX_CNT_EN.
module stream_demux_1_4 #(
  parameter int WIDTH = 4
`ifdef STREAM_DEMUX_CNT_EN
  , parameter int CNT_W = 8
`endif
) (
  input logic               clk,
  input logic               rst,
  stream_demux_1_4_if.slave bus
);
  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} slot_state_t;

  logic [3:0] slot_full;
  logic       push;

  // A slot can accept when empty or when it is being drained this same cycle.
  assign bus.in_ready  = !rst && (!slot_full[bus.in_sel] || bus.out_ready[bus.in_sel]);
  assign push          = bus.in_valid && bus.in_ready;
  assign bus.out_valid = slot_full;

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : gen_slot
      slot_state_t      state_reg;
      logic [WIDTH-1:0] data_reg;
      logic             push_here;
      logic             pop_here;

      assign push_here = push && (bus.in_sel == 2'(gi));
      assign pop_here  = (state_reg == FULL) && bus.out_ready[gi];

      // Push wins over pop so a simultaneous push/pop keeps the slot full with the new beat.
      always_ff @(posedge clk) begin
        if (rst) begin
          state_reg <= EMPTY;
          data_reg  <= '0;
        end else if (push_here) begin
          state_reg <= FULL;
          data_reg  <= bus.in_data;
        end else if (pop_here) begin
          state_reg <= EMPTY;
        end
      end

      assign slot_full[gi]                    = (state_reg == FULL);
      assign bus.out_data[gi*WIDTH +: WIDTH] = data_reg;

`ifdef STREAM_DEMUX_CNT_EN
      logic [CNT_W-1:0] cnt_reg;

      always_ff @(posedge clk) begin
        if (rst) begin
          cnt_reg <= '0;
        end else if (push_here) begin
          cnt_reg <= cnt_reg + 1'b1;
        end
      end

      assign bus.out_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
`endif
    end
  endgenerate
endmodule

// File: tb/tb_stream_demux_1_4.sv
// Self-checking bench for stream_demux_1_4: directed scenarios plus randomized traffic
// compared against a queue-based model of four one-deep output buffers.
module tb_stream_demux_1_4;
  localparam int WIDTH = 4;
`ifdef STREAM_DEMUX_CNT_EN
  localparam int CNT_W = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

`ifdef STREAM_DEMUX_CNT_EN
  stream_demux_1_4_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();
  stream_demux_1_4 #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));
`else
  stream_demux_1_4_if #(.WIDTH(WIDTH)) bus ();
  stream_demux_1_4 #(.WIDTH(WIDTH)) dut (.clk(clk), .rst(rst), .bus(bus));
`endif

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // Model: each output is a FIFO of capacity one; a beat is visible while it sits in the queue.
  logic [WIDTH-1:0] exp_q [4][$];
  int unsigned      m_cnt [4];

  function automatic logic [3:0] m_valid();
    logic [3:0] v;
    for (int i = 0; i < 4; i++) v[i] = (exp_q[i].size() != 0);
    return v;
  endfunction

  function automatic logic m_ready();
    int s;
    s = int'(bus.in_sel);
    return !rst && (exp_q[s].size() == 0 || bus.out_ready[s]);
  endfunction

  // Advance the model by the handshakes present now, then cross one rising edge.
  task automatic tick();
    int s;
    logic acc;
    s   = int'(bus.in_sel);
    acc = bus.in_valid && m_ready();
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        exp_q[i].delete();
        m_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 4; i++)
        if (exp_q[i].size() != 0 && bus.out_ready[i]) void'(exp_q[i].pop_front());
      if (acc) begin
        exp_q[s].push_back(bus.in_data);
        m_cnt[s] = (m_cnt[s] + 1) % 256;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 4'hF; bus.out_ready = 4'b0000;
    tick();
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_in_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    rst = 1'b0; bus.in_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL reset_out_valid: got %b expected 0000", bus.out_valid);
    end
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL reset_idle_ready: got %b expected 1", bus.in_ready);
    end
    n_cmp++;
    if (bus.out_data !== 16'h0000) begin
      n_fail++; $display("FAIL reset_out_data: got %h expected 0000", bus.out_data);
    end
`ifdef STREAM_DEMUX_CNT_EN
    n_cmp++;
    if (bus.out_cnt !== 32'h0) begin
      n_fail++; $display("FAIL reset_out_cnt: got %h expected 0", bus.out_cnt);
    end
`endif
    $display("test_reset: done");
  endtask

  task automatic test_single();
    bus.out_ready = 4'b1111; bus.in_valid = 1'b1; bus.in_sel = 2'd2; bus.in_data = 4'hA;
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 4'b0100) begin
      n_fail++; $display("FAIL single_valid: got %b expected 0100", bus.out_valid);
    end
    n_cmp++;
    if (bus.out_data[11:8] !== 4'hA) begin
      n_fail++; $display("FAIL single_data: got %h expected a", bus.out_data[11:8]);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL single_drain: got %b expected 0000", bus.out_valid);
    end
    $display("test_single: sel2 beat a delivered after one cycle");
  endtask

  task automatic test_stall();
    bus.out_ready = 4'b1101; bus.in_valid = 1'b1; bus.in_sel = 2'd1; bus.in_data = 4'h3;
    tick();
    bus.in_data = 4'h5;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL stall_ready: got %b expected 0", bus.in_ready);
    end
    tick();
    n_cmp++;
    if (bus.out_valid[1] !== 1'b1 || bus.out_data[7:4] !== 4'h3) begin
      n_fail++; $display("FAIL stall_hold: got v=%b d=%h expected v=1 d=3", bus.out_valid[1], bus.out_data[7:4]);
    end
    bus.in_sel = 2'd0; bus.in_data = 4'h7;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1) begin
      n_fail++; $display("FAIL stall_other_ready: got %b expected 1", bus.in_ready);
    end
    tick();
    n_cmp++;
    if (bus.out_valid[0] !== 1'b1 || bus.out_data[3:0] !== 4'h7) begin
      n_fail++; $display("FAIL stall_other_data: got v=%b d=%h expected v=1 d=7", bus.out_valid[0], bus.out_data[3:0]);
    end
    bus.in_sel = 2'd1; bus.in_data = 4'h5; bus.out_ready = 4'b1111;
    #1;
    n_cmp++;
    if (bus.in_ready !== 1'b1 || bus.out_data[7:4] !== 4'h3) begin
      n_fail++; $display("FAIL stall_release: got rdy=%b d=%h expected rdy=1 d=3", bus.in_ready, bus.out_data[7:4]);
    end
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid[1] !== 1'b1 || bus.out_data[7:4] !== 4'h5) begin
      n_fail++; $display("FAIL stall_order: got v=%b d=%h expected v=1 d=5", bus.out_valid[1], bus.out_data[7:4]);
    end
    tick();
    $display("test_stall: sel1 held 3 then delivered 5; sel0 not blocked");
  endtask

  task automatic test_back_to_back();
    logic [WIDTH-1:0] prev;
    bus.out_ready = 4'b1111; bus.in_valid = 1'b0;
    tick();
    prev = '0;
    for (int k = 0; k < 8; k++) begin
      bus.in_valid = 1'b1; bus.in_sel = 2'd3; bus.in_data = WIDTH'($urandom);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
        n_fail++; $display("FAIL b2b_ready[%0d]: got %b expected 1", k, bus.in_ready);
      end
      if (k > 0) begin
        n_cmp++;
        if (bus.out_valid[3] !== 1'b1 || bus.out_data[15:12] !== prev) begin
          n_fail++; $display("FAIL b2b_data[%0d]: got v=%b d=%h expected v=1 d=%h", k, bus.out_valid[3], bus.out_data[15:12], prev);
        end
      end
      prev = bus.in_data;
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid[3] !== 1'b1 || bus.out_data[15:12] !== prev) begin
      n_fail++; $display("FAIL b2b_last: got v=%b d=%h expected v=1 d=%h", bus.out_valid[3], bus.out_data[15:12], prev);
    end
    tick();
    n_cmp++;
    if (bus.out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL b2b_drain: got %b expected 0000", bus.out_valid);
    end
    $display("test_back_to_back: 8 beats to sel3 without bubbles");
  endtask

  task automatic test_flush();
    bus.out_ready = 4'b0000; bus.in_valid = 1'b1; bus.in_sel = 2'd0; bus.in_data = 4'h9;
    tick();
    bus.in_sel = 2'd2; bus.in_data = 4'hC;
    tick();
    bus.in_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 4'b0101) begin
      n_fail++; $display("FAIL flush_fill: got %b expected 0101", bus.out_valid);
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_valid !== 4'b0000 || bus.out_data !== 16'h0000) begin
      n_fail++; $display("FAIL flush_clear: got v=%b d=%h expected v=0000 d=0000", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 4'b1111;
    tick();
    n_cmp++;
    if (bus.out_valid !== 4'b0000) begin
      n_fail++; $display("FAIL flush_no_ghost: got %b expected 0000", bus.out_valid);
    end
    $display("test_flush: buffered beats discarded by reset");
  endtask

  task automatic test_random();
    bit hold;
    hold = 1'b0;
    for (int it = 0; it < 400; it++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!hold) begin
        bus.in_valid = ($urandom_range(0, 3) != 0);
        bus.in_sel   = 2'($urandom_range(0, 3));
        bus.in_data  = WIDTH'($urandom);
      end
      bus.out_ready = 4'($urandom_range(0, 15));
      #1;
      n_cmp++;
      if (bus.in_ready !== m_ready()) begin
        n_fail++; $display("FAIL rand_ready[%0d]: got %b expected %b", it, bus.in_ready, m_ready());
      end
      n_cmp++;
      if (bus.out_valid !== m_valid()) begin
        n_fail++; $display("FAIL rand_valid[%0d]: got %b expected %b", it, bus.out_valid, m_valid());
      end
      for (int i = 0; i < 4; i++) begin
        if (exp_q[i].size() != 0) begin
          n_cmp++;
          if (bus.out_data[i*WIDTH +: WIDTH] !== exp_q[i][0]) begin
            n_fail++; $display("FAIL rand_data[%0d][%0d]: got %h expected %h", it, i, bus.out_data[i*WIDTH +: WIDTH], exp_q[i][0]);
          end
        end
`ifdef STREAM_DEMUX_CNT_EN
        n_cmp++;
        if (bus.out_cnt[i*CNT_W +: CNT_W] !== CNT_W'(m_cnt[i])) begin
          n_fail++; $display("FAIL rand_cnt[%0d][%0d]: got %0d expected %0d", it, i, bus.out_cnt[i*CNT_W +: CNT_W], m_cnt[i]);
        end
`endif
      end
      hold = bus.in_valid && !m_ready();
      tick();
    end
    rst = 1'b0;
    $display("test_random: 400 randomized cycles");
  endtask

`ifdef STREAM_DEMUX_CNT_EN
  task automatic test_cnt_wrap();
    rst = 1'b1; bus.in_valid = 1'b0; bus.out_ready = 4'b1111;
    tick();
    rst = 1'b0; bus.in_valid = 1'b1; bus.in_sel = 2'd0;
    for (int k = 0; k < 257; k++) begin
      bus.in_data = WIDTH'(k);
      tick();
    end
    bus.in_valid = 1'b0;
    #1;
    n_cmp++;
    if (bus.out_cnt !== 32'h0000_0001) begin
      n_fail++; $display("FAIL cnt_wrap: got %h expected 00000001", bus.out_cnt);
    end
    $display("test_cnt_wrap: 257 pushes to sel0");
  endtask
`endif

  initial begin
    bus.in_valid = 1'b0; bus.in_sel = 2'd0; bus.in_data = '0; bus.out_ready = 4'b0000;
    test_reset();
    test_single();
    test_stall();
    test_back_to_back();
    test_flush();
    test_random();
`ifdef STREAM_DEMUX_CNT_EN
    test_cnt_wrap();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
